clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the divisor; the block SHALL support WIDTH >= 2.
REQ-002 Parameter DEFAULT_DIV, default 8, divisor active after reset; the block SHALL require 2 <= DEFAULT_DIV <= 2^WIDTH-1.
REQ-003 clk  input  1  sole clock; all state SHALL be updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 en  input  1  run enable; 1 = divide, 0 = stop at the next period boundary.
REQ-006 div  input  WIDTH  requested divisor N, unsigned.
REQ-007 div_load  input  1  single-cycle strobe that qualifies div.
REQ-008 clk_out  output  1  divided clock, registered, glitch-free.
REQ-009 tick  output  1  one-cycle pulse, coincident with each clk_out rising edge.
REQ-010 div_err  output  1  one-cycle pulse flagging a rejected div_load.

Function
REQ-011 The block SHALL contain a period counter cnt (WIDTH bits), an active divisor act_div, a pending divisor pend_div, a pending-valid flag, and states IDLE and RUN.
REQ-012 In RUN, cnt SHALL count 0..act_div-1 and wrap to 0; the wrap edge is the period boundary.
REQ-013 clk_out SHALL be 1 when cnt < ceil(act_div/2), else 0: even N gives exactly 50% duty; odd N gives (N+1)/2 high and (N-1)/2 low.
REQ-014 tick SHALL be 1 exactly in cycles where state = RUN and cnt = 0.
REQ-015 IDLE -> RUN: en=1 sampled at edge k SHALL give cnt=0, clk_out=1, tick=1 after edge k+1 (one-cycle latency).
REQ-016 RUN -> IDLE: when en=0, the block SHALL finish the current period and enter IDLE at the next boundary instead of wrapping; no truncated high phase is allowed.
REQ-017 In IDLE, clk_out and tick SHALL be 0 and cnt SHALL hold 0.
REQ-018 div_load with div >= 2 SHALL set pend_div=div and pending-valid=1; a later load before activation SHALL overwrite it (last load wins).
REQ-019 div_load with div of 0 or 1 SHALL be rejected: pend_div and act_div unchanged, div_err=1 in the next cycle.
REQ-020 Pending divisor SHALL transfer to act_div only at a period boundary, or on the next edge when in IDLE; pending-valid then clears.
REQ-021 div_load asserted in the cycle where cnt = act_div-1 SHALL take effect at that same boundary (bypass), so the new period uses the new N.
REQ-022 A divisor change SHALL never alter the length of a period already in progress; every clk_out high and low phase SHALL match either the old N or the new N, never a mix.
REQ-023 en=0 and a boundary divisor update in the same cycle SHALL both apply: the block enters IDLE with act_div updated.
REQ-024 Maximum N = 2^WIDTH-1; cnt SHALL never exceed act_div-1.

Reset
REQ-025 When rst=0, immediately and without waiting for clk: clk_out=0, tick=0, div_err=0, cnt=0, state=IDLE, act_div=DEFAULT_DIV, pending-valid=0.
REQ-026 Reset asserted mid-period SHALL truncate clk_out at once; after release, the block SHALL follow REQ-015.

Verification
REQ-027 Reset release, en=1, no load, clk period 10 ns -> clk_out period 80 ns, 40 ns high / 40 ns low, tick once per 80 ns.
REQ-028 Load div=5 while IDLE, then en=1 -> clk_out 3 cycles high, 2 low, repeating; tick every 5 cycles.
REQ-029 Running N=8, load div=4 at cnt=2 -> current period completes as 8 cycles, then 4-cycle periods; no short pulse.
REQ-030 Load div=1, then div=0 -> div_err pulses once for each load; the period stays 8 cycles.
REQ-031 en dropped at cnt=1 with N=8 -> the period runs to cnt=7, then clk_out stays 0 and tick stays 0.
REQ-032 rst=0 asserted while clk_out=1 -> clk_out=0 within the same cycle, before the next clk edge; after release with en=1 -> first tick one cycle later.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider.
// Divides clk by a run-time divisor N (2 .. 2^WIDTH-1). clk_out is high for
// ceil(N/2) cycles and low for floor(N/2) cycles. Divisor changes only take
// effect on a period boundary, so a period that has already started is never
// shortened or stretched. When en drops, the current period is allowed to
// complete before the block stops.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             en_q;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             err_q;

  logic             load_ok;
  logic             boundary;
  logic [WIDTH:0]   half_d;

  assign load_ok  = div_load && (div >= WIDTH'(2));
  assign boundary = (state_q == RUN) && (cnt_q == act_q - WIDTH'(1));

  // Next-state logic. The outputs are derived from the next state so that the
  // registered clk_out/tick line up with the registered counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_v_q) begin
          act_d    = pend_q;
          pend_v_d = 1'b0;
        end
        // en was registered one edge earlier, giving the one-cycle start latency.
        if (en_q) state_d = RUN;
        if (load_ok) begin
          pend_d   = div;
          pend_v_d = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          cnt_d    = '0;
          pend_v_d = 1'b0;
          // A load coinciding with the last cycle is newer than any pending value.
          if (load_ok)       act_d = div;
          else if (pend_v_q) act_d = pend_q;
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (load_ok) begin
            pend_d   = div;
            pend_v_d = 1'b1;
          end
        end
      end
    endcase

    half_d    = ({1'b0, act_d} + (WIDTH+1)'(1)) >> 1;
    clk_out_d = (state_d == RUN) && ({1'b0, cnt_d} < half_d);
    tick_d    = (state_d == RUN) && (cnt_d == '0);
  end

  // State and output registers; reset clears outputs immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= WIDTH'(DEFAULT_DIV);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      en_q      <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      en_q      <= en;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= div_load && (div < WIDTH'(2));
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: stimulus pushes hand-computed tick cycles, high-phase
// lengths and div_err cycles into queues; a monitor pops them as events occur.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div = '0;
  logic       div_load = 1'b0;
  logic       clk_out, tick, div_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int q_tick[$];
  int q_hi[$];
  int q_err[$];

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait until the negedge following clock edge number c.
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ticks(input int first, input int period, input int n, input int hi);
    for (int i = 0; i < n; i++) begin
      q_tick.push_back(first + i * period);
      q_hi.push_back(hi);
    end
  endtask

  // Monitor: sample 1 ns after each rising edge.
  logic prev_out = 1'b0;
  int   hi_len   = 0;
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (tick === 1'b1) begin
      if (q_tick.size() == 0) chk("unexpected_tick", cyc, -1);
      else chk("tick_cycle", cyc, q_tick.pop_front());
    end
    if (div_err === 1'b1) begin
      if (q_err.size() == 0) chk("unexpected_div_err", cyc, -1);
      else chk("div_err_cycle", cyc, q_err.pop_front());
    end
    if (clk_out === 1'b1) hi_len++;
    else if (prev_out) begin
      if (q_hi.size() == 0) chk("unexpected_high_phase", hi_len, -1);
      else chk("high_len", hi_len, q_hi.pop_front());
      hi_len = 0;
    end
    prev_out = (clk_out === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int c0, c1, c2;

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_div_err", int'(div_err), 0);
    at(2);
    rst = 1'b1;

    // Default N=8: 4 high/4 low. Rejected loads of 1 and 0; en dropped at cnt=1.
    at(3);
    c0 = cyc;
    en = 1'b1;
    push_ticks(c0 + 2, 8, 3, 4);
    q_err.push_back(c0 + 6);
    q_err.push_back(c0 + 7);
    at(c0 + 5);
    div = 8'd1; div_load = 1'b1;
    at(c0 + 6);
    div = 8'd0;
    at(c0 + 7);
    div_load = 1'b0;
    at(c0 + 19);
    en = 1'b0;

    // Load 5 while idle, then run: 3 high / 2 low.
    c1 = c0 + 30;
    at(c1);
    push_ticks(c1 + 5, 5, 3, 3);
    push_ticks(c1 + 20, 8, 2, 4);
    push_ticks(c1 + 36, 4, 3, 2);
    q_tick.push_back(c1 + 48);
    q_hi.push_back(1);
    div = 8'd5; div_load = 1'b1;
    at(c1 + 1);
    div_load = 1'b0;
    at(c1 + 3);
    chk("idle_clk_out", int'(clk_out), 0);
    en = 1'b1;
    // Load 8 in the last cycle of an N=5 period: bypass applies at that boundary.
    at(c1 + 19);
    div = 8'd8; div_load = 1'b1;
    at(c1 + 20);
    div_load = 1'b0;
    // Load 4 at cnt=2 of an N=8 period: current period still completes as 8.
    at(c1 + 30);
    div = 8'd4; div_load = 1'b1;
    at(c1 + 31);
    div_load = 1'b0;

    // Reset while clk_out is high truncates it immediately.
    at(c1 + 48);
    chk("pre_rst_clk_out", int'(clk_out), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_tick", int'(tick), 0);
    at(c1 + 51);
    c2 = cyc;
    push_ticks(c2 + 2, 8, 2, 4);
    rst = 1'b1;
    at(c2 + 11);
    en = 1'b0;
    at(c2 + 25);
    chk("final_clk_out", int'(clk_out), 0);
    chk("left_ticks", q_tick.size(), 0);
    chk("left_highs", q_hi.size(), 0);
    chk("left_errs", q_err.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
